// File: rtl/xmr_pipe_pkg.sv
// rtl/xmr_pipe_pkg.sv - shared types and constants for the XMR skid retiming chain
package xmr_pipe_pkg;

   typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_t;

   localparam int XMR_STALL_CNT_W = 16;

   // Number of beats a single skid stage holds in a given state.
   function automatic logic [1:0] skid_beats(input skid_state_t s);
      case (s)
         SKID_BUSY: return 2'd1;
         SKID_FULL: return 2'd2;
         default:   return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/xmr_skid_stage.sv
// rtl/xmr_skid_stage.sv - one 2-entry skid stage; in_ready comes straight from a flop
module xmr_skid_stage
   import xmr_pipe_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
`ifdef XMR_PIPE_STATS_EN
   ,
   output logic [1:0]        beats
`endif
);

   skid_state_t       r_state;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              w_in_fire;
   logic              w_out_fire;

   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = r_out_valid && out_ready;

   // in_ready/out_valid are updated together with the state so both are pure flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SKID_EMPTY;
         r_main      <= RESET_VAL;
         r_skid      <= RESET_VAL;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            SKID_EMPTY: begin
               if (w_in_fire) begin
                  r_main      <= in_data;
                  r_state     <= SKID_BUSY;
                  r_out_valid <= 1'b1;
               end
            end
            SKID_BUSY: begin
               if (w_in_fire && !w_out_fire) begin
                  r_skid     <= in_data;
                  r_state    <= SKID_FULL;
                  r_in_ready <= 1'b0;
               end else if (w_in_fire && w_out_fire) begin
                  r_main <= in_data;
               end else if (w_out_fire) begin
                  r_state     <= SKID_EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            SKID_FULL: begin
               if (w_out_fire) begin
                  r_main     <= r_skid;
                  r_state    <= SKID_BUSY;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= SKID_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_main;

`ifdef XMR_PIPE_STATS_EN
   assign beats = skid_beats(r_state);
`endif

endmodule

// File: rtl/xmr_skid_pipe.sv
// rtl/xmr_skid_pipe.sv - elastic chain of STAGES skid stages for XMR-punched signals
// Optional stall/occupancy statistics are built when XMR_PIPE_STATS_EN is defined.
module xmr_skid_pipe
   import xmr_pipe_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                STAGES    = 2,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready
`ifdef XMR_PIPE_STATS_EN
   ,
   output logic [XMR_STALL_CNT_W-1:0] stall_cnt,
   output logic [$clog2(2*STAGES+1)-1:0] occupancy
`endif
);

   logic              w_valid [0:STAGES];
   logic [DATA_W-1:0] w_data  [0:STAGES];
   logic              w_ready [0:STAGES];
`ifdef XMR_PIPE_STATS_EN
   logic [1:0]        w_beats [0:STAGES-1];
`endif

   assign w_valid[0]      = in_valid;
   assign w_data[0]       = in_data;
   assign in_ready        = w_ready[0];
   assign out_valid       = w_valid[STAGES];
   assign out_data        = w_data[STAGES];
   assign w_ready[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      xmr_skid_stage #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (w_valid[k]),
         .in_data   (w_data[k]),
         .in_ready  (w_ready[k]),
         .out_valid (w_valid[k+1]),
         .out_data  (w_data[k+1]),
         .out_ready (w_ready[k+1])
`ifdef XMR_PIPE_STATS_EN
         ,
         .beats     (w_beats[k])
`endif
      );
   end

`ifdef XMR_PIPE_STATS_EN
   localparam int OCC_W = $clog2(2*STAGES+1);

   logic [XMR_STALL_CNT_W-1:0] r_stall_cnt;
   logic [OCC_W-1:0]           w_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_valid[STAGES] && !out_ready && (r_stall_cnt != {XMR_STALL_CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   always_comb begin
      w_occ = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_occ = w_occ + OCC_W'(w_beats[k]);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign occupancy = w_occ;
`endif

endmodule
